ifft_cp_inserter: RTL and testbench

Consumer of the IFFT core's Avalon-ST source port in the OFDM transmit chain. Accepts one IFFT output block of N complex samples with its block-floating-point exponent, normalises it to a fixed scale, stores it, and replays it as a cyclic-prefixed OFDM symbol of CP+N samples toward the DAC/up-conversion path. It drives the IFFT's `source_ready` and uses it as backpressure while a symbol is being played out.

---
 rtl/ifft_cp_inserter.sv | 186 ++++++++++++++++++
 tb/tb_ifft_cp_inserter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module   : ifft_cp_inserter
// Purpose  : Normalises one IFFT output block by its exponent, stores it and
//            replays it as a cyclic-prefixed OFDM symbol of CP+N samples.
// Revision : 1.0  initial release
// ============================================================================
module ifft_cp_inserter #(
   parameter int N         = 64,
   parameter int CP        = 16,
   parameter int MAX_SHIFT = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_error,
   input  logic       in_sop,
   input  logic       in_eop,
   input  logic [7:0] in_real,
   input  logic [7:0] in_imag,
   input  logic [5:0] in_exp,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sop,
   output logic       out_eop,
   output logic [7:0] out_real,
   output logic [7:0] out_imag,
   output logic       frame_err
);

   localparam int AW = $clog2(N);
   localparam int CW = $clog2(CP + N);
   localparam logic [AW-1:0] c_LAST   = AW'(N - 1);
   localparam logic [AW-1:0] c_START  = AW'(N - CP);
   localparam logic [CW-1:0] c_PENULT = CW'(CP + N - 2);
   localparam bit            c_BYPASS = (CP == 1);

   typedef enum logic {FILL = 1'b0, PLAY = 1'b1} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_wr_cnt;
   logic            r_in_frame;
   logic [5:0]      r_exp;
   logic            r_frame_err;
   logic            r_out_valid;
   logic            r_out_sop;
   logic            r_out_eop;
   logic [7:0]      r_out_real;
   logic [7:0]      r_out_imag;
   logic [AW-1:0]   r_rd_idx;
   logic [CW-1:0]   r_beat;
   logic [15:0]     r_mem [N];

   logic [5:0]      w_exp;
   logic [6:0]      w_neg;
   logic [6:0]      w_k;
   logic [7:0]      w_re;
   logic [7:0]      w_im;
   logic            w_accept;
   logic            w_beat_in_frame;
   logic [AW-1:0]   w_idx;
   logic            w_bad;
   logic            w_wr_en;
   logic [AW-1:0]   w_rd_nxt;
   logic [15:0]     w_rd;
   logic [15:0]     w_first;

   // Sign-extend, shift left by k, saturate to the 8-bit signed range.
   function automatic logic [7:0] f_norm(input logic [7:0] x, input logic [6:0] k);
      logic signed [15:0] t;
      t = $signed({{8{x[7]}}, x}) <<< k;
      if (t > 16'sd127)
         return 8'h7F;
      else if (t < -16'sd128)
         return 8'h80;
      else
         return t[7:0];
   endfunction

   always_comb begin
      w_exp = in_sop ? in_exp : r_exp;
      w_neg = 7'd0 - {w_exp[5], w_exp};
      if (!w_exp[5])
         w_k = 7'd0;
      else if (w_neg > 7'(MAX_SHIFT))
         w_k = 7'(MAX_SHIFT);
      else
         w_k = w_neg;
   end

   assign w_re            = f_norm(in_real, w_k);
   assign w_im            = f_norm(in_imag, w_k);
   assign in_ready        = (r_state == FILL) && !reset;
   assign w_accept        = in_valid && in_ready;
   assign w_beat_in_frame = in_sop || r_in_frame;
   assign w_idx           = in_sop ? '0 : r_wr_cnt;
   assign w_bad           = (in_error != 2'b00) || (in_eop != (w_idx == c_LAST));
   assign w_wr_en         = w_accept && w_beat_in_frame && !w_bad;
   assign w_rd_nxt        = (r_rd_idx == c_LAST) ? '0 : r_rd_idx + 1'b1;
   assign w_rd            = r_mem[w_rd_nxt];
   // With CP=1 the first prefix sample is the one being written this cycle.
   assign w_first         = c_BYPASS ? {w_re, w_im} : r_mem[c_START];

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[w_idx] <= {w_re, w_im};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= FILL;
         r_wr_cnt    <= '0;
         r_in_frame  <= 1'b0;
         r_exp       <= '0;
         r_frame_err <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_real  <= '0;
         r_out_imag  <= '0;
         r_rd_idx    <= '0;
         r_beat      <= '0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  if (in_sop)
                     r_exp <= in_exp;
                  if (in_sop && r_in_frame)
                     r_frame_err <= 1'b1;
                  if (w_beat_in_frame) begin
                     if (w_bad) begin
                        r_frame_err <= 1'b1;
                        r_in_frame  <= 1'b0;
                        r_wr_cnt    <= '0;
                     end else if (w_idx == c_LAST) begin
                        r_state     <= PLAY;
                        r_in_frame  <= 1'b0;
                        r_wr_cnt    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b1;
                        r_out_eop   <= 1'b0;
                        r_rd_idx    <= c_START;
                        r_beat      <= '0;
                        r_out_real  <= w_first[15:8];
                        r_out_imag  <= w_first[7:0];
                     end else begin
                        r_in_frame  <= 1'b1;
                        r_wr_cnt    <= w_idx + 1'b1;
                     end
                  end
               end
            end
            PLAY: begin
               if (out_ready) begin
                  if (r_out_eop) begin
                     r_state     <= FILL;
                     r_out_valid <= 1'b0;
                     r_out_sop   <= 1'b0;
                     r_out_eop   <= 1'b0;
                  end else begin
                     r_rd_idx    <= w_rd_nxt;
                     r_beat      <= r_beat + 1'b1;
                     r_out_sop   <= 1'b0;
                     r_out_eop   <= (r_beat == c_PENULT);
                     r_out_real  <= w_rd[15:8];
                     r_out_imag  <= w_rd[7:0];
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_sop   = r_out_sop;
   assign out_eop   = r_out_eop;
   assign out_real  = r_out_real;
   assign out_imag  = r_out_imag;
   assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ifft_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifft_cp_inserter
// Purpose  : Directed, table-driven bench for ifft_cp_inserter (N=64/CP=16 and
//            an N=8/CP=8 instance sharing the same input stream).
// Revision : 1.0  initial release
// ============================================================================
module tb_ifft_cp_inserter;

   localparam int N1  = 64;
   localparam int CP1 = 16;
   localparam int L1  = N1 + CP1;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_sop, in_eop;
   logic [1:0] in_error;
   logic [7:0] in_real, in_imag;
   logic [5:0] in_exp;
   logic       out_ready;
   logic       in_ready, out_valid, out_sop, out_eop, frame_err;
   logic [7:0] out_real, out_imag;
   logic       in_ready2, out_valid2, out_sop2, out_eop2, frame_err2;
   logic [7:0] out_real2, out_imag2;

   always #5 clk = ~clk;

   ifft_cp_inserter #(.N(N1), .CP(CP1), .MAX_SHIFT(7)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_error(in_error), .in_sop(in_sop), .in_eop(in_eop),
      .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
      .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
      .out_eop(out_eop), .out_real(out_real), .out_imag(out_imag),
      .frame_err(frame_err)
   );

   ifft_cp_inserter #(.N(8), .CP(8), .MAX_SHIFT(7)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_error(in_error), .in_sop(in_sop), .in_eop(in_eop),
      .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
      .out_valid(out_valid2), .out_ready(out_ready), .out_sop(out_sop2),
      .out_eop(out_eop2), .out_real(out_real2), .out_imag(out_imag2),
      .frame_err(frame_err2)
   );

   typedef struct {
      logic [5:0] ex;
      int         re;
      int         im;
      int         xre;
      int         xim;
   } scale_t;

   scale_t tbl [10];

   int n_checks = 0;
   int n_errors = 0;
   int tb_re [N1];
   int tb_im [N1];
   int ex_re [N1];
   int ex_im [N1];
   int g_fe_cnt, g_fe_idx;
   bit g_ov_last, g_ov_pre;

   logic [7:0] q_re [$];
   logic [7:0] q_im [$];
   bit         q_sop [$];
   bit         q_eop [$];
   logic [7:0] q2_re [$];
   logic [7:0] q2_im [$];
   bit         q2_sop [$];
   bit         q2_eop [$];
   int n_sym = 0, n_sym2 = 0, n_vcyc = 0;
   int hold_err = 0, bubble_err = 0, ready_err = 0, nrdy_err = 0, fe2_cnt = 0;
   bit in_sym = 0, stalled = 0;
   logic [17:0] last_word = '0;

   // Output observer for the N=64 instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         in_sym  = 0;
         stalled = 0;
      end else if (out_valid) begin
         n_vcyc++;
         if (in_ready) ready_err++;
         if (stalled && ({out_real, out_imag, out_sop, out_eop} != last_word)) hold_err++;
         if (out_ready) begin
            q_re.push_back(out_real);
            q_im.push_back(out_imag);
            q_sop.push_back(out_sop);
            q_eop.push_back(out_eop);
            if (out_sop) in_sym = 1;
            if (out_eop) begin
               in_sym = 0;
               n_sym++;
            end
         end
         stalled   = !out_ready;
         last_word = {out_real, out_imag, out_sop, out_eop};
      end else begin
         if (in_sym) bubble_err++;
         stalled = 0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err2) fe2_cnt++;
         if (out_valid2 && in_ready2) ready_err++;
         if (out_valid2 && out_ready) begin
            q2_re.push_back(out_real2);
            q2_im.push_back(out_imag2);
            q2_sop.push_back(out_sop2);
            q2_eop.push_back(out_eop2);
            if (out_eop2) n_sym2++;
         end
      end
   end

   task automatic chk(input string nm, input bit ok, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic clear_mon();
      q_re.delete(); q_im.delete(); q_sop.delete(); q_eop.delete();
      n_sym = 0; n_vcyc = 0; hold_err = 0;
   endtask

   task automatic beat(input bit sop, input bit eop, input logic [1:0] err,
                       input logic [7:0] re, input logic [7:0] im,
                       input logic [5:0] ex, output bit fe, output bit ov);
      in_valid = 1'b1; in_sop = sop; in_eop = eop; in_error = err;
      in_real = re; in_imag = im; in_exp = ex;
      if (!in_ready) nrdy_err++;
      @(posedge clk); #1;
      fe = frame_err;
      ov = out_valid;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 2'b00;
   endtask

   // Non-first beats carry exponent +31 so a design that ignores the latched
   // exponent scales them differently.
   task automatic send_run(input int n, input bit sop0, input bit eopl,
                           input int err_at, input logic [5:0] ex);
      bit fe, ov;
      g_fe_cnt = 0; g_fe_idx = -1; g_ov_last = 0; g_ov_pre = 0;
      for (int i = 0; i < n; i++) begin
         beat(sop0 && (i == 0), eopl && (i == n - 1), (i == err_at) ? 2'b01 : 2'b00,
              8'(tb_re[i]), 8'(tb_im[i]), (i == 0) ? ex : 6'd31, fe, ov);
         if (fe) begin
            g_fe_cnt++;
            if (g_fe_idx < 0) g_fe_idx = i;
         end
         if (i == n - 1) g_ov_last = ov;
         if (i == n - 2) g_ov_pre = ov;
      end
      @(posedge clk); #1;
      if (frame_err) begin
         g_fe_cnt++;
         if (g_fe_idx < 0) g_fe_idx = n;
      end
   endtask

   task automatic wait_sym(input bit bp, input string nm);
      int c;
      c = 0;
      while (n_sym == 0 && c < 600) begin
         @(posedge clk); #1;
         out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         c++;
      end
      chk({nm, "_symbol_done"}, n_sym != 0, n_sym, 1);
   endtask

   task automatic check_sym(input string nm);
      int bad, bad_f;
      bad = 0; bad_f = 0;
      chk({nm, "_beats"}, q_re.size() == L1, q_re.size(), L1);
      for (int j = 0; j < q_re.size() && j < L1; j++) begin
         int k;
         k = (j < CP1) ? (N1 - CP1 + j) : (j - CP1);
         if (q_re[j] != 8'(ex_re[k]) || q_im[j] != 8'(ex_im[k])) bad++;
         if (q_sop[j] != (j == 0) || q_eop[j] != (j == L1 - 1)) bad_f++;
      end
      chk({nm, "_data_bad_beats"}, bad == 0, bad, 0);
      chk({nm, "_sop_eop_bad_beats"}, bad_f == 0, bad_f, 0);
   endtask

   task automatic idle_no_output(input string nm);
      repeat (100) @(posedge clk);
      #1;
      chk({nm, "_no_output"}, q_re.size() == 0, q_re.size(), 0);
   endtask

   task automatic set_ramp(input int base, input int step, input int ibase, input int istep);
      for (int i = 0; i < N1; i++) begin
         tb_re[i] = base + step * i;
         tb_im[i] = ibase + istep * i;
         ex_re[i] = tb_re[i];
         ex_im[i] = tb_im[i];
      end
   endtask

   initial begin
      tbl[0] = '{6'(-3),  5,    -7,   40,   -56};
      tbl[1] = '{6'(-3),  20,   -20,  127,  -128};
      tbl[2] = '{6'(2),   9,    -9,   9,    -9};
      tbl[3] = '{6'(-12), 1,    -1,   127,  -128};
      tbl[4] = '{6'(0),   -128, 127,  -128, 127};
      tbl[5] = '{6'(-1),  63,   -64,  126,  -128};
      tbl[6] = '{6'(-1),  64,   -65,  127,  -128};
      tbl[7] = '{6'(-32), 0,    2,    0,    127};
      tbl[8] = '{6'(31),  -5,   100,  -5,   100};
      tbl[9] = '{6'(-7),  -1,   0,    -128, 0};

      reset = 1'b1; out_ready = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 2'b00;
      in_real = '0; in_imag = '0; in_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready == 1'b0, in_ready, 0);
      chk("reset_outputs", {out_valid, out_sop, out_eop, frame_err, out_real, out_imag} == '0,
          {out_valid, out_sop, out_eop, frame_err, out_real, out_imag}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("release_in_ready", in_ready == 1'b1, in_ready, 1);
      chk("release_out_valid", out_valid == 1'b0, out_valid, 0);

      // Nominal ramp.
      clear_mon();
      set_ramp(-32, 1, 0, 0);
      send_run(N1, 1, 1, -1, 6'd0);
      chk("nom_valid_before_eop", g_ov_pre == 1'b0, g_ov_pre, 0);
      chk("nom_valid_after_eop", g_ov_last == 1'b1, g_ov_last, 1);
      wait_sym(0, "nom");
      chk("nom_in_ready_after", in_ready == 1'b1, in_ready, 1);
      chk("nom_first_real", q_re.size() > 0 && q_re[0] == 8'd16, q_re.size() > 0 ? int'($signed(q_re[0])) : -999, 16);
      chk("nom_valid_cycles", n_vcyc == L1, n_vcyc, L1);
      check_sym("nom");

      // Scaling / saturation table.
      foreach (tbl[t]) begin
         clear_mon();
         for (int i = 0; i < N1; i++) begin
            tb_re[i] = tbl[t].re;  tb_im[i] = tbl[t].im;
            ex_re[i] = tbl[t].xre; ex_im[i] = tbl[t].xim;
         end
         send_run(N1, 1, 1, -1, tbl[t].ex);
         wait_sym(0, $sformatf("scale%0d", t));
         check_sym($sformatf("scale%0d", t));
      end

      // Backpressure 1,0,0,1.
      clear_mon();
      set_ramp(-40, 1, 20, -1);
      send_run(N1, 1, 1, -1, 6'd0);
      wait_sym(1, "bp");
      out_ready = 1'b1;
      check_sym("bp");
      chk("bp_hold_changes", hold_err == 0, hold_err, 0);

      // Framing errors.
      clear_mon();
      set_ramp(0, 1, 0, 1);
      send_run(11, 1, 1, -1, 6'd0);
      chk("eop10_fe_pulses", g_fe_cnt == 1, g_fe_cnt, 1);
      chk("eop10_fe_beat", g_fe_idx == 10, g_fe_idx, 10);
      idle_no_output("eop10");

      send_run(N1, 1, 0, -1, 6'd0);
      chk("noeop_fe_pulses", g_fe_cnt == 1, g_fe_cnt, 1);
      chk("noeop_fe_beat", g_fe_idx == 63, g_fe_idx, 63);
      idle_no_output("noeop");

      send_run(6, 1, 0, 5, 6'd0);
      chk("err5_fe_pulses", g_fe_cnt == 1, g_fe_cnt, 1);
      chk("err5_fe_beat", g_fe_idx == 5, g_fe_idx, 5);
      send_run(4, 0, 0, -1, 6'd0);
      chk("stray_beats_fe", g_fe_cnt == 0, g_fe_cnt, 0);
      idle_no_output("err5");

      send_run(30, 1, 0, -1, 6'd0);
      chk("sop30_pre_fe", g_fe_cnt == 0, g_fe_cnt, 0);
      set_ramp(50, -1, -10, 1);
      send_run(N1, 1, 1, -1, 6'd0);
      chk("sop30_fe_pulses", g_fe_cnt == 1, g_fe_cnt, 1);
      chk("sop30_fe_beat", g_fe_idx == 0, g_fe_idx, 0);
      wait_sym(0, "sop30");
      check_sym("sop30");

      // Reset in the middle of playback.
      clear_mon();
      set_ramp(-32, 1, 5, 0);
      send_run(N1, 1, 1, -1, 6'd0);
      for (int c = 0; c < 300 && q_re.size() < 40; c++) begin
         @(posedge clk); #1;
      end
      chk("rst_reached_beat40", q_re.size() >= 40, q_re.size(), 40);
      reset = 1'b1;
      #1;
      chk("rst_out_valid_async", out_valid == 1'b0, out_valid, 0);
      chk("rst_outputs_async", {out_sop, out_eop, out_real, out_imag} == '0,
          {out_sop, out_eop, out_real, out_imag}, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready_after", in_ready == 1'b1, in_ready, 1);
      clear_mon();
      set_ramp(-64, 2, 63, -1);
      send_run(N1, 1, 1, -1, 6'd0);
      wait_sym(0, "after_rst");
      check_sym("after_rst");

      // CP = N = 8 on the second instance.
      chk("n8_idle_before", q2_re.size() == 0, q2_re.size(), 0);
      for (int i = 0; i < 8; i++) begin
         tb_re[i] = i;
         tb_im[i] = 7 - i;
      end
      fe2_cnt = 0;
      send_run(8, 1, 1, -1, 6'd0);
      for (int c = 0; c < 100 && n_sym2 == 0; c++) begin
         @(posedge clk); #1;
      end
      chk("n8_fe", fe2_cnt == 0, fe2_cnt, 0);
      chk("n8_beats", q2_re.size() == 16, q2_re.size(), 16);
      begin
         int bad;
         bad = 0;
         for (int j = 0; j < q2_re.size() && j < 16; j++) begin
            if (q2_re[j] != 8'(j % 8) || q2_im[j] != 8'(7 - (j % 8))) bad++;
            if (q2_sop[j] != (j == 0) || q2_eop[j] != (j == 15)) bad++;
         end
         chk("n8_data_bad_beats", bad == 0, bad, 0);
      end

      chk("in_ready_low_in_play", ready_err == 0, ready_err, 0);
      chk("in_ready_high_in_fill", nrdy_err == 0, nrdy_err, 0);
      chk("no_mid_symbol_drop", bubble_err == 0, bubble_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
